// File: rtl/eth_frame_tx.sv
// RMII Ethernet II transmitter: preamble/SFD, header, payload, zero pad and CRC-32 FCS
// streamed as LSB-first dibits, followed by an enforced inter-frame gap.
module eth_frame_tx #(
  parameter int unsigned PAYLOAD_BYTES = 46,
  parameter logic [47:0] DEST_MAC      = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int unsigned IFG_CYCLES    = 48
) (
  input  logic                       eth_clk,
  input  logic                       eth_rst_n,
  input  logic                       start,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 eth_txd,
  output logic                       eth_txen
);

  localparam int unsigned PadBytes = (PAYLOAD_BYTES < 46) ? 46 - PAYLOAD_BYTES : 0;
  localparam int unsigned ByteW    = $clog2(1518);
  localparam int unsigned IfgW     = $clog2(IFG_CYCLES + 1);

  localparam logic [111:0]     Header      = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [ByteW-1:0] LastPre     = ByteW'(7);
  localparam logic [ByteW-1:0] LastHdr     = ByteW'(13);
  localparam logic [ByteW-1:0] LastPayload = ByteW'(PAYLOAD_BYTES - 1);
  localparam logic [ByteW-1:0] LastPad     = ByteW'(PadBytes - 1);
  localparam logic [ByteW-1:0] LastFcs     = ByteW'(3);
  localparam logic [IfgW-1:0]  IfgLast     = IfgW'(IFG_CYCLES - 1);
  localparam logic [31:0]      CrcPoly     = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    StIdle, StPreamble, StHeader, StPayload, StPad, StFcs, StIfg
  } state_e;

  state_e                     state_q, st_n, st_after;
  logic [ByteW-1:0]           byte_q, byte_n;
  logic [1:0]                 dibit_q, dibit_n;
  logic [IfgW-1:0]            ifg_q;
  logic [31:0]                crc_q;
  logic [8*PAYLOAD_BYTES-1:0] payload_q;
  logic                       last_byte;
  logic [7:0]                 tx_byte;
  logic [1:0]                 tx_dibit;

  function automatic logic [31:0] crc_step(logic [31:0] crc, logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CrcPoly : 32'h0);
    end
    return c;
  endfunction

  // Next wire position (state, byte, dibit) and the dibit that belongs there.
  always_comb begin
    st_n      = state_q;
    st_after  = state_q;
    byte_n    = byte_q;
    dibit_n   = dibit_q + 2'd1;
    last_byte = 1'b0;
    case (state_q)
      StPreamble: begin last_byte = (byte_q == LastPre);     st_after = StHeader;  end
      StHeader:   begin last_byte = (byte_q == LastHdr);     st_after = StPayload; end
      StPayload:  begin
        last_byte = (byte_q == LastPayload);
        st_after  = (PadBytes > 0) ? StPad : StFcs;
      end
      StPad:      begin last_byte = (byte_q == LastPad);     st_after = StFcs;     end
      StFcs:      begin last_byte = (byte_q == LastFcs);     st_after = StIfg;     end
      default:    begin last_byte = 1'b0;                    st_after = state_q;   end
    endcase

    if (state_q == StIdle) begin
      st_n    = StPreamble;
      byte_n  = '0;
      dibit_n = '0;
    end else if (dibit_q == 2'd3) begin
      if (last_byte) begin
        st_n   = st_after;
        byte_n = '0;
      end else begin
        byte_n = byte_q + ByteW'(1);
      end
    end

    case (st_n)
      StPreamble: tx_byte = (byte_n == LastPre) ? 8'hD5 : 8'h55;
      StHeader:   tx_byte = 8'(Header >> (8 * (13 - 32'(byte_n))));
      StPayload:  tx_byte = 8'(payload_q >> (8 * (PAYLOAD_BYTES - 1 - 32'(byte_n))));
      StFcs:      tx_byte = 8'(~crc_q >> (8 * 32'(byte_n)));
      default:    tx_byte = 8'h00;
    endcase
    tx_dibit = 2'(tx_byte >> {dibit_n, 1'b0});
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q   <= StIdle;
      byte_q    <= '0;
      dibit_q   <= '0;
      ifg_q     <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      payload_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eth_txd   <= 2'b00;
      eth_txen  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            payload_q <= payload;
            state_q   <= st_n;
            byte_q    <= byte_n;
            dibit_q   <= dibit_n;
            // CRC is untouched during the preamble, so seeding here equals seeding at HEADER.
            crc_q     <= 32'hFFFF_FFFF;
            busy      <= 1'b1;
            eth_txen  <= 1'b1;
            eth_txd   <= tx_dibit;
          end
        end
        StIfg: begin
          if (ifg_q == IfgLast) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            ifg_q <= ifg_q + IfgW'(1);
          end
        end
        default: begin
          state_q <= st_n;
          byte_q  <= byte_n;
          dibit_q <= dibit_n;
          if (st_n == StIfg) begin
            eth_txen <= 1'b0;
            eth_txd  <= 2'b00;
            done     <= 1'b1;
            ifg_q    <= '0;
          end else begin
            eth_txd <= tx_dibit;
            if (st_n inside {StHeader, StPayload, StPad}) begin
              crc_q <= crc_step(crc_q, tx_dibit);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: three payload sizes, back-to-back starts and mid-frame reset.
module tb_eth_frame_tx;

  logic         eth_clk = 1'b0;
  logic         eth_rst_n;
  logic [2:0]   start_v, txen_w, busy_w, done_w;
  logic [5:0]   txd_w;
  logic [8*46-1:0]  pay0;
  logic [8*4-1:0]   pay1;
  logic [8*100-1:0] pay2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] rx_d [$];
  logic [7:0] rx_b [$];
  logic [7:0] exp_pay [$];

  always #10 eth_clk = ~eth_clk;

  eth_frame_tx u_def (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .start(start_v[0]), .payload(pay0),
    .busy(busy_w[0]), .done(done_w[0]), .eth_txd(txd_w[1:0]), .eth_txen(txen_w[0])
  );

  eth_frame_tx #(.PAYLOAD_BYTES(4)) u_small (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .start(start_v[1]), .payload(pay1),
    .busy(busy_w[1]), .done(done_w[1]), .eth_txd(txd_w[3:2]), .eth_txen(txen_w[1])
  );

  eth_frame_tx #(.PAYLOAD_BYTES(100)) u_big (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .start(start_v[2]), .payload(pay2),
    .busy(busy_w[2]), .done(done_w[2]), .eth_txd(txd_w[5:4]), .eth_txen(txen_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ b[i]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
      else c = c >> 1;
    end
    return c;
  endfunction

  task automatic pulse_start(input logic [1:0] sel);
    @(negedge eth_clk);
    start_v[sel] = 1'b1;
    @(negedge eth_clk);
    start_v[sel] = 1'b0;
  endtask

  // Collect dibits while txen is high, then follow busy through the gap.
  task automatic capture(input logic [1:0] sel, input int mutate_at, output int len,
                         output int done_end, output int ifg, output int bad);
    rx_d.delete();
    len = 0;
    bad = 0;
    ifg = 0;
    while (txen_w[sel] === 1'b1 && len < 2000) begin
      rx_d.push_back(2'(txd_w >> {sel, 1'b0}));
      if (done_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) bad++;
      len++;
      if (len == mutate_at) pay0 = {46{8'h5A}};
      @(negedge eth_clk);
    end
    done_end = 32'(done_w[sel]);
    while (busy_w[sel] === 1'b1 && ifg < 2000) begin
      @(negedge eth_clk);
      ifg++;
      if (done_w[sel] !== 1'b0 || txen_w[sel] !== 1'b0) bad++;
    end
  endtask

  task automatic check_frame(input string pfx, input int len, input int exp_len);
    logic [7:0]   exp_f [$];
    logic [111:0] hdr;
    logic [31:0]  crc;
    logic [31:0]  fcs_rx;
    int ones, bad, base;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    check({pfx, "_len"}, len, exp_len);
    ones = 0;
    for (int i = 0; i < 31 && i < rx_d.size(); i++) if (rx_d[i] == 2'b01) ones++;
    check({pfx, "_preamble"}, ones, 31);
    check({pfx, "_sfd"}, (rx_d.size() > 31) ? 32'(rx_d[31]) : 32'hFF, 32'h3);
    rx_b.delete();
    for (int k = 0; k + 3 < rx_d.size(); k += 4)
      rx_b.push_back({rx_d[k+3], rx_d[k+2], rx_d[k+1], rx_d[k]});
    for (int i = 0; i < 14; i++) exp_f.push_back(8'(hdr >> (8 * (13 - i))));
    foreach (exp_pay[i]) exp_f.push_back(exp_pay[i]);
    while (exp_f.size() < 60) exp_f.push_back(8'h00);
    bad = 0;
    foreach (exp_f[i]) if (8 + i >= rx_b.size() || rx_b[8 + i] !== exp_f[i]) bad++;
    check({pfx, "_bytes_bad"}, bad, 0);
    crc = 32'hFFFF_FFFF;
    foreach (exp_f[i]) crc = crc_byte(crc, exp_f[i]);
    base = 8 + exp_f.size();
    fcs_rx = (rx_b.size() >= base + 4) ?
             {rx_b[base+3], rx_b[base+2], rx_b[base+1], rx_b[base]} : 32'h0;
    check({pfx, "_fcs"}, fcs_rx, ~crc);
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < rx_b.size(); i++) crc = crc_byte(crc, rx_b[i]);
    check({pfx, "_residue"}, crc, 32'hDEBB_20E3);
  endtask

  task automatic fill_exp(input logic [7:0] v, input int n);
    exp_pay.delete();
    for (int i = 0; i < n; i++) exp_pay.push_back(v);
  endtask

  initial begin
    int len, dn, ifg, bad, g, cnt;
    logic [7:0] b;
    eth_rst_n = 1'b0;
    start_v   = '0;
    pay0      = '0;
    pay1      = '0;
    pay2      = '0;
    repeat (3) @(negedge eth_clk);
    check("reset_state", 32'({txen_w, busy_w, done_w, txd_w}), 32'h0);
    eth_rst_n = 1'b1;
    repeat (2) @(negedge eth_clk);

    // Default 46-byte frame, payload A5
    pay0 = {46{8'hA5}};
    fill_exp(8'hA5, 46);
    pulse_start(2'd0);
    check("def_txen_latency", 32'(txen_w[0]), 32'h1);
    check("def_busy_rise", 32'(busy_w[0]), 32'h1);
    capture(2'd0, 0, len, dn, ifg, bad);
    check_frame("def", len, 288);
    check("def_done", dn, 1);
    check("def_ifg", ifg, 48);
    check("def_flags_bad", bad, 0);
    cnt = 0;
    for (int i = 32; i < 56 && i < rx_d.size(); i++) if (rx_d[i] == 2'b11) cnt++;
    check("hdr_dest_dibits", cnt, 24);
    check("hdr_src_dibits",
          (rx_d.size() > 59) ? 32'({rx_d[56], rx_d[57], rx_d[58], rx_d[59]}) : 32'hFFFF,
          32'h80);
    check("hdr_ethertype", (rx_b.size() > 21) ? 32'({rx_b[20], rx_b[21]}) : 32'h0, 32'h88B5);

    // 4-byte payload: 42 pad bytes
    pay1 = 32'h3132_3334;
    exp_pay.delete();
    exp_pay.push_back(8'h31); exp_pay.push_back(8'h32);
    exp_pay.push_back(8'h33); exp_pay.push_back(8'h34);
    pulse_start(2'd1);
    capture(2'd1, 0, len, dn, ifg, bad);
    check_frame("small", len, 288);
    cnt = 0;
    for (int i = 26; i < 68 && i < rx_b.size(); i++) if (rx_b[i] == 8'h00) cnt++;
    check("small_pad_zeros", cnt, 42);
    check("small_done", dn, 1);
    check("small_flags_bad", bad, 0);

    // 100-byte payload: no padding
    exp_pay.delete();
    for (int i = 0; i < 100; i++) begin
      b = 8'(i * 7 + 3);
      exp_pay.push_back(b);
      pay2 = {pay2[8*99-1:0], b};
    end
    pulse_start(2'd2);
    capture(2'd2, 0, len, dn, ifg, bad);
    check_frame("big", len, 504);
    check("big_done", dn, 1);
    check("big_ifg", ifg, 48);

    // start held high: back-to-back frames, payload changed mid-frame
    pay0 = {46{8'hA5}};
    fill_exp(8'hA5, 46);
    @(negedge eth_clk);
    start_v[0] = 1'b1;
    @(negedge eth_clk);
    check("cont_txen_latency", 32'(txen_w[0]), 32'h1);
    capture(2'd0, 100, len, dn, ifg, bad);
    check_frame("cont1", len, 288);
    g = 0;
    while (txen_w[0] !== 1'b1 && g < 200) begin
      @(negedge eth_clk);
      g++;
    end
    check("cont_gap", ifg + g, 49);
    start_v[0] = 1'b0;
    fill_exp(8'h5A, 46);
    capture(2'd0, 0, len, dn, ifg, bad);
    check_frame("cont2", len, 288);

    // Reset in the middle of the payload
    pay0 = {46{8'hA5}};
    fill_exp(8'hA5, 46);
    pulse_start(2'd0);
    repeat (150) @(negedge eth_clk);
    check("rst_pre_txen", 32'(txen_w[0]), 32'h1);
    @(posedge eth_clk);
    #3 eth_rst_n = 1'b0;
    #1;
    check("rst_async", 32'({txen_w[0], busy_w[0], done_w[0], txd_w[1:0]}), 32'h0);
    repeat (2) @(negedge eth_clk);
    eth_rst_n = 1'b1;
    dn = 0;
    g  = 0;
    repeat (80) begin
      @(negedge eth_clk);
      if (done_w[0] !== 1'b0) dn++;
      if (txen_w[0] !== 1'b0 || busy_w[0] !== 1'b0) g++;
    end
    check("rst_no_done", dn, 0);
    check("rst_stays_idle", g, 0);
    pulse_start(2'd0);
    capture(2'd0, 0, len, dn, ifg, bad);
    check_frame("post_rst", len, 288);
    check("post_rst_done", dn, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
